// File: rtl/reg_file_n_bit_pkg.sv
// Shared sizing constants for the register file and the ALU units that consume its operands.
package reg_file_n_bit_pkg;
  localparam int WORD_SIZE = 32;
  localparam int ADDR_SIZE = 5;
  localparam int ZERO_REG  = 0;
endpackage

// File: rtl/reg_file_n_bit_if.sv
// Operand read / write-back bus between the ALU operand stage and the register file.
interface reg_file_n_bit_if #(
  parameter int word_size = reg_file_n_bit_pkg::WORD_SIZE,
  parameter int addr_size = reg_file_n_bit_pkg::ADDR_SIZE
) ();
  logic                 rd_en;
  logic [addr_size-1:0] RA1;
  logic [addr_size-1:0] RA2;
  logic                 W_en;
  logic [addr_size-1:0] WA;
  logic [word_size-1:0] W_data;
  logic [word_size-1:0] R1;
  logic [word_size-1:0] R2;
  logic                 R_valid;

  modport master (
    output rd_en, RA1, RA2, W_en, WA, W_data,
    input  R1, R2, R_valid
  );

  modport slave (
    input  rd_en, RA1, RA2, W_en, WA, W_data,
    output R1, R2, R_valid
  );
endinterface

// File: rtl/reg_file_n_bit_read_port.sv
// One registered read port: address mux, zero-register check, write-back forwarding, hold.
module reg_read_port_n_bit
  import reg_file_n_bit_pkg::*;
#(
  parameter int word_size = WORD_SIZE,
  parameter int addr_size = ADDR_SIZE,
  parameter int num_regs  = 1 << addr_size
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                rd_en,
  input  logic [addr_size-1:0]                ra,
  input  logic                                w_en,
  input  logic [addr_size-1:0]                wa,
  input  logic [word_size-1:0]                w_data,
  input  logic [num_regs-1:0][word_size-1:0]  regs,
  output logic [word_size-1:0]                rd
);
  localparam logic [addr_size-1:0] zero_addr = addr_size'(ZERO_REG);

  logic [word_size-1:0] rd_d, rd_q;

  always_comb begin
    rd_d = rd_q;
    if (rd_en) begin
      if (ra == zero_addr) begin
        rd_d = '0;
      end else if (w_en && (wa == ra)) begin
        // ra is non-zero here, so this also implies the write is not to reg 0
        rd_d = w_data;
      end else begin
        rd_d = regs[ra];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q <= '0;
    end else begin
      rd_q <= rd_d;
    end
  end

  assign rd = rd_q;
endmodule

// File: rtl/reg_file_n_bit.sv
// Register file feeding the ALU operand stage: one write-back per cycle, two registered reads.
module reg_file_n_bit
  import reg_file_n_bit_pkg::*;
#(
  parameter int word_size = WORD_SIZE,
  parameter int addr_size = ADDR_SIZE
) (
  input logic              clk,
  input logic              rst,
  reg_file_n_bit_if.slave  bus
);
  localparam int                   num_regs  = 1 << addr_size;
  localparam logic [addr_size-1:0] zero_addr = addr_size'(ZERO_REG);

  logic [num_regs-1:0][word_size-1:0] regs_d, regs_q;
  logic                               r_valid_d, r_valid_q;
  logic [word_size-1:0]               r1, r2;

  always_comb begin
    regs_d = regs_q;
    if (bus.W_en && (bus.WA != zero_addr)) begin
      regs_d[bus.WA] = bus.W_data;
    end
    r_valid_d = bus.rd_en;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q    <= '0;
      r_valid_q <= 1'b0;
    end else begin
      regs_q    <= regs_d;
      r_valid_q <= r_valid_d;
    end
  end

  reg_read_port_n_bit #(
    .word_size (word_size),
    .addr_size (addr_size),
    .num_regs  (num_regs)
  ) u_port1 (
    .clk    (clk),
    .rst    (rst),
    .rd_en  (bus.rd_en),
    .ra     (bus.RA1),
    .w_en   (bus.W_en),
    .wa     (bus.WA),
    .w_data (bus.W_data),
    .regs   (regs_q),
    .rd     (r1)
  );

  reg_read_port_n_bit #(
    .word_size (word_size),
    .addr_size (addr_size),
    .num_regs  (num_regs)
  ) u_port2 (
    .clk    (clk),
    .rst    (rst),
    .rd_en  (bus.rd_en),
    .ra     (bus.RA2),
    .w_en   (bus.W_en),
    .wa     (bus.WA),
    .w_data (bus.W_data),
    .regs   (regs_q),
    .rd     (r2)
  );

  assign bus.R1      = r1;
  assign bus.R2      = r2;
  assign bus.R_valid = r_valid_q;
endmodule

// File: tb/tb_reg_file_n_bit.sv
// Directed bench for reg_file_n_bit: reset, write/read, forwarding, zero reg, hold, reset mid-read.
module tb_reg_file_n_bit;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  reg_file_n_bit_if #(.word_size(32), .addr_size(5)) bus ();

  reg_file_n_bit #(.word_size(32), .addr_size(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // inputs change and outputs are sampled 1ns after each rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.rd_en  = 1'b0;
    bus.RA1    = '0;
    bus.RA2    = '0;
    bus.W_en   = 1'b0;
    bus.WA     = '0;
    bus.W_data = '0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    idle();
    bus.W_en   = 1'b1;
    bus.WA     = a;
    bus.W_data = d;
    cyc();
  endtask

  task automatic test_reset();
    n_cmp++;
    if (bus.R1 !== 32'h0 || bus.R2 !== 32'h0 || bus.R_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_initial: R1=%h R2=%h R_valid=%b, required 0/0/0", bus.R1, bus.R2, bus.R_valid);
    end
    for (int i = 1; i < 32; i++) begin
      idle();
      bus.W_en   = 1'b1;
      bus.WA     = 5'(i);
      bus.W_data = 32'(i) * 32'h01010101;
      bus.rd_en  = 1'b1;
      bus.RA1    = 5'(i);
      bus.RA2    = 5'(i);
      cyc();
    end
    n_cmp++;
    if (bus.R1 !== 32'h1f1f1f1f || bus.R_valid !== 1'b1) begin
      n_err++;
      $display("FAIL reset_preload: R1=%h R_valid=%b, required 1f1f1f1f/1", bus.R1, bus.R_valid);
    end
    rst = 1'b1;
    bus.W_en = 1'b0;
    cyc();
    rst = 1'b0;
    n_cmp++;
    if (bus.R1 !== 32'h0 || bus.R2 !== 32'h0 || bus.R_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_after: R1=%h R2=%h R_valid=%b, required 0/0/0", bus.R1, bus.R2, bus.R_valid);
    end
    for (int i = 0; i < 32; i++) begin
      idle();
      bus.rd_en = 1'b1;
      bus.RA1   = 5'(i);
      bus.RA2   = 5'(31 - i);
      cyc();
      n_cmp++;
      if (bus.R1 !== 32'h0 || bus.R2 !== 32'h0 || bus.R_valid !== 1'b1) begin
        n_err++;
        $display("FAIL reset_read_all[%0d]: R1=%h R2=%h R_valid=%b, required 0/0/1", i, bus.R1, bus.R2, bus.R_valid);
      end
    end
    idle();
  endtask

  task automatic test_write_read();
    wr(5'd5, 32'hDEADBEEF);
    idle();
    bus.rd_en = 1'b1;
    bus.RA1   = 5'd5;
    bus.RA2   = 5'd0;
    cyc();
    n_cmp++;
    if (bus.R1 !== 32'hDEADBEEF || bus.R2 !== 32'h0 || bus.R_valid !== 1'b1) begin
      n_err++;
      $display("FAIL write_read: R1=%h R2=%h R_valid=%b, required deadbeef/0/1", bus.R1, bus.R2, bus.R_valid);
    end
    idle();
  endtask

  task automatic test_forwarding();
    wr(5'd7, 32'h1);
    idle();
    bus.W_en   = 1'b1;
    bus.WA     = 5'd7;
    bus.W_data = 32'hA5A5A5A5;
    bus.rd_en  = 1'b1;
    bus.RA1    = 5'd7;
    bus.RA2    = 5'd7;
    cyc();
    n_cmp++;
    if (bus.R1 !== 32'hA5A5A5A5 || bus.R2 !== 32'hA5A5A5A5) begin
      n_err++;
      $display("FAIL forwarding: R1=%h R2=%h, required a5a5a5a5/a5a5a5a5", bus.R1, bus.R2);
    end
    // one port forwarded, the other reading stored reg5
    idle();
    bus.W_en   = 1'b1;
    bus.WA     = 5'd7;
    bus.W_data = 32'h12345678;
    bus.rd_en  = 1'b1;
    bus.RA1    = 5'd5;
    bus.RA2    = 5'd7;
    cyc();
    n_cmp++;
    if (bus.R1 !== 32'hDEADBEEF || bus.R2 !== 32'h12345678) begin
      n_err++;
      $display("FAIL forwarding_split: R1=%h R2=%h, required deadbeef/12345678", bus.R1, bus.R2);
    end
    idle();
    bus.rd_en = 1'b1;
    bus.RA1   = 5'd7;
    bus.RA2   = 5'd7;
    cyc();
    n_cmp++;
    if (bus.R1 !== 32'h12345678 || bus.R2 !== 32'h12345678) begin
      n_err++;
      $display("FAIL forwarding_stored: R1=%h R2=%h, required 12345678/12345678", bus.R1, bus.R2);
    end
    idle();
  endtask

  task automatic test_zero_reg();
    idle();
    bus.W_en   = 1'b1;
    bus.WA     = 5'd0;
    bus.W_data = 32'hFFFFFFFF;
    bus.rd_en  = 1'b1;
    bus.RA1    = 5'd0;
    bus.RA2    = 5'd5;
    cyc();
    n_cmp++;
    if (bus.R1 !== 32'h0 || bus.R2 !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL zero_same_cycle: R1=%h R2=%h, required 0/deadbeef", bus.R1, bus.R2);
    end
    idle();
    bus.rd_en = 1'b1;
    bus.RA1   = 5'd0;
    bus.RA2   = 5'd0;
    cyc();
    n_cmp++;
    if (bus.R1 !== 32'h0 || bus.R2 !== 32'h0) begin
      n_err++;
      $display("FAIL zero_later: R1=%h R2=%h, required 0/0", bus.R1, bus.R2);
    end
    idle();
  endtask

  task automatic test_hold_valid();
    logic [31:0] exp_r1 [3];
    logic        exp_v  [5];
    exp_r1[0] = 32'h11111111;
    exp_r1[1] = 32'h22222222;
    exp_r1[2] = 32'h33333333;
    exp_v[0] = 1'b1; exp_v[1] = 1'b1; exp_v[2] = 1'b1; exp_v[3] = 1'b0; exp_v[4] = 1'b0;
    wr(5'd1, 32'h11111111);
    wr(5'd2, 32'h22222222);
    wr(5'd3, 32'h33333333);
    for (int i = 0; i < 5; i++) begin
      idle();
      bus.rd_en = (i < 3);
      bus.RA1   = (i < 3) ? 5'(i + 1) : 5'd5;
      bus.RA2   = 5'd7;
      cyc();
      n_cmp++;
      if (bus.R_valid !== exp_v[i] || bus.R1 !== exp_r1[(i < 3) ? i : 2]) begin
        n_err++;
        $display("FAIL hold_valid[%0d]: R1=%h R_valid=%b, required %h/%b", i, bus.R1, bus.R_valid,
                 exp_r1[(i < 3) ? i : 2], exp_v[i]);
      end
    end
    idle();
  endtask

  task automatic test_reset_mid_read();
    wr(5'd4, 32'h44444444);
    idle();
    rst        = 1'b1;
    bus.rd_en  = 1'b1;
    bus.RA1    = 5'd4;
    bus.RA2    = 5'd4;
    bus.W_en   = 1'b1;
    bus.WA     = 5'd6;
    bus.W_data = 32'h66666666;
    cyc();
    rst = 1'b0;
    n_cmp++;
    if (bus.R_valid !== 1'b0 || bus.R1 !== 32'h0 || bus.R2 !== 32'h0) begin
      n_err++;
      $display("FAIL reset_mid_read: R1=%h R2=%h R_valid=%b, required 0/0/0", bus.R1, bus.R2, bus.R_valid);
    end
    idle();
    bus.rd_en = 1'b1;
    bus.RA1   = 5'd6;
    bus.RA2   = 5'd4;
    cyc();
    n_cmp++;
    if (bus.R1 !== 32'h0 || bus.R2 !== 32'h0 || bus.R_valid !== 1'b1) begin
      n_err++;
      $display("FAIL reset_mid_write_dropped: R1=%h R2=%h R_valid=%b, required 0/0/1", bus.R1, bus.R2, bus.R_valid);
    end
    idle();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    idle();
    cyc();
    cyc();
    rst = 1'b0;
    test_reset();
    test_write_read();
    test_forwarding();
    test_zero_reg();
    test_hold_valid();
    test_reset_mid_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
